// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and widths for the two-source UDP TX arbiter.
package udp_tx_arbiter_pkg;

  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int AXIS_USER_W = 1;
  localparam int AXIS_ID_W   = 4;
  localparam int AXIS_DEST_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // Chooses which pending header to take next. With both pending, round-robin
  // favours whichever source was not served last; fixed priority favours 0.
  function automatic logic select_source(input logic valid0,
                                         input logic valid1,
                                         input logic last_grant,
                                         input logic round_robin);
    if (valid0 && valid1) begin
      return round_robin ? ~last_grant : 1'b0;
    end
    return valid1 && !valid0;
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// UDP TX header and AXI-Stream payload interfaces used by the arbiter.
interface UDP_TX_HEADER_IF;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [7:0]  ip_ttl;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;
  logic [15:0] checksum;

  modport Source (
    output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
    input  hdr_ready
  );

  modport Sink (
    input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
    output hdr_ready
  );
endinterface

interface AXIS_IF;
  import udp_tx_arbiter_pkg::*;

  logic                   tvalid;
  logic                   tready;
  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tstrb;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tlast;
  logic [AXIS_ID_W-1:0]   tid;
  logic [AXIS_DEST_W-1:0] tdest;
  logic [AXIS_USER_W-1:0] tuser;
  logic                   twakeup;

  modport Transmitter (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport Receiver (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    output tready
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Two-source UDP TX arbiter: takes one header from the selected source,
// presents it downstream, then passes that source's payload through until
// tlast, counting completed packets per source.
module udp_tx_arbiter
  import udp_tx_arbiter_pkg::*;
#(
  parameter logic ROUND_ROBIN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  UDP_TX_HEADER_IF.Sink         in0_hdr_if,
  AXIS_IF.Receiver              in0_payload_if,
  UDP_TX_HEADER_IF.Sink         in1_hdr_if,
  AXIS_IF.Receiver              in1_payload_if,
  UDP_TX_HEADER_IF.Source       out_hdr_if,
  AXIS_IF.Transmitter           out_payload_if,
  output logic                  grant,
  output logic                  busy,
  output logic [15:0]           pkt_count0,
  output logic [15:0]           pkt_count1
);

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   sel;
  logic   hdr_accept;
  logic   hdr_done;
  logic   pkt_done;

  assign sel      = select_source(in0_hdr_if.hdr_valid, in1_hdr_if.hdr_valid,
                                  last_grant, ROUND_ROBIN);
  assign hdr_done = (state == HEADER) && out_hdr_if.hdr_valid && out_hdr_if.hdr_ready;
  assign busy     = (state != IDLE);

  // Next-state decode and the input header handshake, offered only in IDLE
  always_comb begin
    state_next           = state;
    hdr_accept           = 1'b0;
    in0_hdr_if.hdr_ready = 1'b0;
    in1_hdr_if.hdr_ready = 1'b0;
    case (state)
      IDLE: begin
        if (in0_hdr_if.hdr_valid || in1_hdr_if.hdr_valid) begin
          hdr_accept = 1'b1;
          if (sel) begin
            in1_hdr_if.hdr_ready = 1'b1;
          end else begin
            in0_hdr_if.hdr_ready = 1'b1;
          end
          state_next = HEADER;
        end
      end
      HEADER: begin
        if (hdr_done) begin
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pkt_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero-latency payload path from the granted source; everything is held off outside PAYLOAD
  always_comb begin
    out_payload_if.tvalid  = 1'b0;
    out_payload_if.tdata   = '0;
    out_payload_if.tstrb   = '0;
    out_payload_if.tkeep   = '0;
    out_payload_if.tlast   = 1'b0;
    out_payload_if.tid     = '0;
    out_payload_if.tdest   = '0;
    out_payload_if.tuser   = '0;
    out_payload_if.twakeup = 1'b0;
    in0_payload_if.tready  = 1'b0;
    in1_payload_if.tready  = 1'b0;
    pkt_done               = 1'b0;
    if (state == PAYLOAD) begin
      if (grant) begin
        out_payload_if.tvalid  = in1_payload_if.tvalid;
        out_payload_if.tdata   = in1_payload_if.tdata;
        out_payload_if.tstrb   = in1_payload_if.tstrb;
        out_payload_if.tkeep   = in1_payload_if.tkeep;
        out_payload_if.tlast   = in1_payload_if.tlast;
        out_payload_if.tid     = in1_payload_if.tid;
        out_payload_if.tdest   = in1_payload_if.tdest;
        out_payload_if.tuser   = in1_payload_if.tuser;
        out_payload_if.twakeup = in1_payload_if.twakeup;
        in1_payload_if.tready  = out_payload_if.tready;
        pkt_done = in1_payload_if.tvalid && out_payload_if.tready && in1_payload_if.tlast;
      end else begin
        out_payload_if.tvalid  = in0_payload_if.tvalid;
        out_payload_if.tdata   = in0_payload_if.tdata;
        out_payload_if.tstrb   = in0_payload_if.tstrb;
        out_payload_if.tkeep   = in0_payload_if.tkeep;
        out_payload_if.tlast   = in0_payload_if.tlast;
        out_payload_if.tid     = in0_payload_if.tid;
        out_payload_if.tdest   = in0_payload_if.tdest;
        out_payload_if.tuser   = in0_payload_if.tuser;
        out_payload_if.twakeup = in0_payload_if.twakeup;
        in0_payload_if.tready  = out_payload_if.tready;
        pkt_done = in0_payload_if.tvalid && out_payload_if.tready && in0_payload_if.tlast;
      end
    end
  end

  // State register, header capture on acceptance and grant bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      grant                   <= 1'b0;
      last_grant              <= 1'b1;
      out_hdr_if.hdr_valid    <= 1'b0;
      out_hdr_if.ip_dscp      <= '0;
      out_hdr_if.ip_ecn       <= '0;
      out_hdr_if.ip_ttl       <= '0;
      out_hdr_if.ip_source_ip <= '0;
      out_hdr_if.ip_dest_ip   <= '0;
      out_hdr_if.source_port  <= '0;
      out_hdr_if.dest_port    <= '0;
      out_hdr_if.length       <= '0;
      out_hdr_if.checksum     <= '0;
    end else begin
      state <= state_next;
      if (hdr_accept) begin
        grant                   <= sel;
        out_hdr_if.hdr_valid    <= 1'b1;
        out_hdr_if.ip_dscp      <= sel ? in1_hdr_if.ip_dscp      : in0_hdr_if.ip_dscp;
        out_hdr_if.ip_ecn       <= sel ? in1_hdr_if.ip_ecn       : in0_hdr_if.ip_ecn;
        out_hdr_if.ip_ttl       <= sel ? in1_hdr_if.ip_ttl       : in0_hdr_if.ip_ttl;
        out_hdr_if.ip_source_ip <= sel ? in1_hdr_if.ip_source_ip : in0_hdr_if.ip_source_ip;
        out_hdr_if.ip_dest_ip   <= sel ? in1_hdr_if.ip_dest_ip   : in0_hdr_if.ip_dest_ip;
        out_hdr_if.source_port  <= sel ? in1_hdr_if.source_port  : in0_hdr_if.source_port;
        out_hdr_if.dest_port    <= sel ? in1_hdr_if.dest_port    : in0_hdr_if.dest_port;
        out_hdr_if.length       <= sel ? in1_hdr_if.length       : in0_hdr_if.length;
        out_hdr_if.checksum     <= sel ? in1_hdr_if.checksum     : in0_hdr_if.checksum;
      end else if (hdr_done) begin
        out_hdr_if.hdr_valid <= 1'b0;
      end
      if (pkt_done) begin
        last_grant <= grant;
      end
    end
  end

  // Completed-packet counters; 16-bit arithmetic wraps 0xFFFF to 0x0000
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else if (pkt_done) begin
      if (grant) begin
        pkt_count1 <= pkt_count1 + 16'd1;
      end else begin
        pkt_count0 <= pkt_count0 + 16'd1;
      end
    end
  end

endmodule
